// File: rtl/fdu_pkg.sv
// Shared decode constants for the fetch/decode unit: instruction field offsets
// as functions of the register-address width, HALT opcode, and opcode classes.
package fdu_pkg;

  localparam logic [3:0] HALT_OP_DEF = 4'hF;
  localparam logic [3:0] OPC_WR_LAST = 4'h7;

  // Layout, MSB first: cond[2] | opcode[4] | rd | rs1 | rs2 | shift[1]
  function automatic int fdu_instr_w(input int ra_w);
    return 7 + 3 * ra_w;
  endfunction

  function automatic int fdu_off_rs2(input int ra_w);
    return (ra_w > 0) ? 1 : 1;
  endfunction

  function automatic int fdu_off_rs1(input int ra_w);
    return 1 + ra_w;
  endfunction

  function automatic int fdu_off_rd(input int ra_w);
    return 1 + 2 * ra_w;
  endfunction

  function automatic int fdu_off_op(input int ra_w);
    return 1 + 3 * ra_w;
  endfunction

  function automatic int fdu_off_cond(input int ra_w);
    return 5 + 3 * ra_w;
  endfunction

  function automatic logic fdu_op_writes_rd(input logic [3:0] op);
    return op <= OPC_WR_LAST;
  endfunction

endpackage

// File: rtl/fdu_skid_buf.sv
// One-entry holding slot for a fetched word and its pc while decode is stalled.
// A flush empties it regardless of push/pop; push wins over pop (refill on drain).
module fdu_skid_buf
  import fdu_pkg::*;
#(
  parameter int DATA_W = fdu_instr_w(3),
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [PC_W-1:0]   o_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [PC_W-1:0]   r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_decode_unit.sv
// Program counter, synchronous imem fetch and registered decode stage behind a
// valid/ready handshake; stall, redirect/flush and HALT handling.
module fetch_decode_unit
  import fdu_pkg::*;
#(
  parameter int         PC_W    = 4,
  parameter int         RA_W    = 3,
  parameter logic [3:0] HALT_OP = HALT_OP_DEF,
  localparam int        INSTR_W = fdu_instr_w(RA_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PC_W-1:0]      o_imem_addr,
  output logic                 o_imem_en,
  input  logic [INSTR_W-1:0]   i_imem_rdata,
  input  logic                 i_branch_taken,
  input  logic [PC_W-1:0]      i_branch_target,
  input  logic                 i_dec_ready,
  output logic                 o_dec_valid,
  output logic [PC_W-1:0]      o_dec_pc,
  output logic [1:0]           o_dec_cond,
  output logic [3:0]           o_dec_opcode,
  output logic [RA_W-1:0]      o_dec_rd,
  output logic [RA_W-1:0]      o_dec_rs1,
  output logic [RA_W-1:0]      o_dec_rs2,
  output logic                 o_dec_shift,
  output logic [2**RA_W-1:0]   o_dec_en,
  output logic                 o_halted
);

  localparam int COND_LO = fdu_off_cond(RA_W);
  localparam int OP_LO   = fdu_off_op(RA_W);
  localparam int RD_LO   = fdu_off_rd(RA_W);
  localparam int RS1_LO  = fdu_off_rs1(RA_W);
  localparam int RS2_LO  = fdu_off_rs2(RA_W);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0]    r_pc, r_f_pc, r_dec_pc;
  logic               r_f_valid, r_dec_valid, r_halted;
  logic [INSTR_W-1:0] r_dec_instr;
  logic [2**RA_W-1:0] r_dec_en;

  logic               w_skid_valid, w_skid_push, w_skid_pop, w_skid_nxt;
  logic [INSTR_W-1:0] w_skid_data, w_src_data;
  logic [PC_W-1:0]    w_skid_pc, w_src_pc;
  logic               w_load, w_src_valid, w_halt_load, w_imem_en, w_flush;
  logic [3:0]         w_src_op;
  logic [RA_W-1:0]    w_src_rd;
  logic [2**RA_W-1:0] w_src_en;

  assign w_load      = !r_dec_valid || i_dec_ready;
  assign w_src_valid = w_skid_valid || r_f_valid;
  assign w_src_data  = w_skid_valid ? w_skid_data : i_imem_rdata;
  assign w_src_pc    = w_skid_valid ? w_skid_pc : r_f_pc;
  assign w_src_op    = w_src_data[OP_LO +: 4];
  assign w_src_rd    = w_src_data[RD_LO +: RA_W];
  assign w_halt_load = w_load && w_src_valid && (w_src_op == HALT_OP) && !i_branch_taken;

  always_comb begin
    w_src_en = '0;
    if (fdu_op_writes_rd(w_src_op)) w_src_en[w_src_rd] = 1'b1;
  end

  // Only issue a read if the word returning next cycle is sure to have a slot.
  assign w_skid_nxt  = w_load ? (w_skid_valid && r_f_valid) : (w_skid_valid || r_f_valid);
  assign w_imem_en   = rst_n && !r_halted && !i_branch_taken && !w_skid_nxt;
  assign w_skid_push = r_f_valid && (!w_load || w_skid_valid);
  assign w_skid_pop  = w_load && w_skid_valid;
  assign w_flush     = i_branch_taken || w_halt_load;

  fdu_skid_buf #(.DATA_W(INSTR_W), .PC_W(PC_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_data  (i_imem_rdata),
    .i_pc    (r_f_pc),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_f_pc      <= '0;
      r_f_valid   <= 1'b0;
      r_dec_valid <= 1'b0;
      r_dec_pc    <= '0;
      r_dec_instr <= '0;
      r_dec_en    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_f_pc <= r_pc;
      if (i_branch_taken) begin
        r_pc        <= i_branch_target;
        r_f_valid   <= 1'b0;
        r_dec_valid <= 1'b0;
        r_halted    <= 1'b0;
      end else begin
        if (w_imem_en) r_pc <= r_pc + PC_ONE;
        r_f_valid <= w_imem_en && !w_halt_load;
        if (w_load) begin
          r_dec_valid <= w_src_valid;
          if (w_src_valid) begin
            r_dec_pc    <= w_src_pc;
            r_dec_instr <= w_src_data;
            r_dec_en    <= w_src_en;
          end
        end
        if (w_halt_load) r_halted <= 1'b1;
      end
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_imem_en    = w_imem_en;
  assign o_dec_valid  = r_dec_valid;
  assign o_dec_pc     = r_dec_pc;
  assign o_dec_cond   = r_dec_instr[COND_LO +: 2];
  assign o_dec_opcode = r_dec_instr[OP_LO +: 4];
  assign o_dec_rd     = r_dec_instr[RD_LO +: RA_W];
  assign o_dec_rs1    = r_dec_instr[RS1_LO +: RA_W];
  assign o_dec_rs2    = r_dec_instr[RS2_LO +: RA_W];
  assign o_dec_shift  = r_dec_instr[0];
  assign o_dec_en     = r_dec_en;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: ROM-backed imem, program-order scoreboard,
// randomized ready/ROM contents, stall, redirect, HALT, wrap and reset cases.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [3:0]  branch_target = '0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [3:0]  dec_pc;
  logic [1:0]  dec_cond;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_shift;
  logic [7:0]  dec_en;
  logic        halted;

  logic [15:0] rom [16];
  int vecs = 0;
  int errs = 0;

  logic        x;
  logic [3:0]  p;
  logic [15:0] w;
  logic [7:0]  e;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  fetch_decode_unit dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_addr(imem_addr), .o_imem_en(imem_en), .i_imem_rdata(imem_rdata),
    .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .i_dec_ready(dec_ready), .o_dec_valid(dec_valid), .o_dec_pc(dec_pc),
    .o_dec_cond(dec_cond), .o_dec_opcode(dec_opcode), .o_dec_rd(dec_rd),
    .o_dec_rs1(dec_rs1), .o_dec_rs2(dec_rs2), .o_dec_shift(dec_shift),
    .o_dec_en(dec_en), .o_halted(halted)
  );

  // Write-enable rule straight from the ISA: opcodes 0-7 write rd, 8-F do not.
  function automatic logic [7:0] exp_en(input logic [15:0] word);
    if (word[13:10] >= 4'd8) return 8'h00;
    return 8'h01 << word[9:7];
  endfunction

  task automatic tick(input logic rdy, input logic br, input logic [3:0] tgt,
                      output logic xf, output logic [3:0] pc_o,
                      output logic [15:0] w_o, output logic [7:0] en_o);
    @(negedge clk);
    dec_ready = rdy; branch_taken = br; branch_target = tgt;
    #1;
    xf   = dec_valid && rdy;
    pc_o = dec_pc;
    w_o  = {dec_cond, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_shift};
    en_o = dec_en;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; dec_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_counting_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'(i);
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (imem_en !== 1'b0) begin errs++; $display("FAIL reset_imem_en got %b want 0", imem_en); end
    vecs++; if (imem_addr !== 4'h0) begin errs++; $display("FAIL reset_imem_addr got %h want 0", imem_addr); end
    vecs++; if ({dec_valid, halted} !== 2'b00) begin errs++; $display("FAIL reset_valid_halted got %b want 00", {dec_valid, halted}); end
    vecs++;
    if ({dec_pc, dec_cond, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_shift, dec_en} !== 28'h0) begin
      errs++; $display("FAIL reset_dec_fields got pc=%h en=%h op=%h want all 0", dec_pc, dec_en, dec_opcode);
    end
  endtask

  task automatic test_sequential();
    fill_counting_rom();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      vecs++;
      if (k < 2) begin
        if (x !== 1'b0) begin errs++; $display("FAIL seq_latency sample=%0d got valid=%b want 0", k, x); end
      end else if (x !== 1'b1 || p !== 4'(k - 2) || w !== rom[k-2] || e !== exp_en(rom[k-2])) begin
        errs++; $display("FAIL seq_b2b sample=%0d got v=%b pc=%h w=%h en=%h want v=1 pc=%h w=%h",
                         k, x, p, w, e, 4'(k - 2), rom[k-2]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ep;
    int nx;
    fill_counting_rom();
    do_reset();
    ep = 4'h0; nx = 0;
    for (int k = 1; k <= 24; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      if (x) begin
        vecs++;
        if (p !== ep || w !== rom[ep]) begin errs++; $display("FAIL wrap_seq got pc=%h w=%h want pc=%h w=%h", p, w, ep, rom[ep]); end
        ep = ep + 4'h1; nx++;
      end
    end
    vecs++; if (nx !== 23) begin errs++; $display("FAIL wrap_count got %0d transfers want 23", nx); end
  endtask

  task automatic test_decode_random();
    logic [3:0] ep, hp;
    logic [15:0] hw, r;
    logic rdy, prev_stall;
    int nx;
    for (int i = 0; i < 16; i++) begin
      r = 16'($urandom);
      if (r[13:10] == 4'hF) r[13:10] = 4'hE;
      rom[i] = r;
    end
    rom[5] = 16'h1E8D;
    rom[6] = 16'h228D;
    do_reset();
    ep = 4'h0; nx = 0; prev_stall = 1'b0; hp = '0; hw = '0;
    for (int k = 0; k < 90; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      tick(rdy, 1'b0, 4'h0, x, p, w, e);
      if (prev_stall) begin
        vecs++;
        if (dec_valid !== 1'b1 || p !== hp || w !== hw) begin
          errs++; $display("FAIL stall_hold got v=%b pc=%h w=%h want v=1 pc=%h w=%h", dec_valid, p, w, hp, hw);
        end
      end
      if (x) begin
        vecs++;
        if (p !== ep || w !== rom[ep] || e !== exp_en(rom[ep])) begin
          errs++; $display("FAIL rand_xfer got pc=%h w=%h en=%h want pc=%h w=%h en=%h", p, w, e, ep, rom[ep], exp_en(rom[ep]));
        end
        if (ep == 4'h5) begin vecs++; if (e !== 8'b0010_0000) begin errs++; $display("FAIL en_1e8d got %b want 00100000", e); end end
        if (ep == 4'h6) begin vecs++; if (e !== 8'h00) begin errs++; $display("FAIL en_op8 got %b want 00000000", e); end end
        ep = ep + 4'h1; nx++;
      end
      prev_stall = dec_valid && !rdy; hp = p; hw = w;
    end
    vecs++; if (nx < 30) begin errs++; $display("FAIL rand_progress got %0d transfers want >=30", nx); end
  endtask

  task automatic test_stall();
    logic [3:0] ep, fp;
    fill_counting_rom();
    do_reset();
    ep = 4'h0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      if (x) begin
        vecs++; if (p !== ep) begin errs++; $display("FAIL stall_pre got pc=%h want %h", p, ep); end
        ep = ep + 4'h1;
      end
    end
    fp = ep;
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b0, 4'h0, x, p, w, e);
      vecs++;
      if (dec_valid !== 1'b1 || p !== fp) begin errs++; $display("FAIL stall_frozen cyc=%0d got v=%b pc=%h want v=1 pc=%h", k, dec_valid, p, fp); end
      if (k >= 2) begin
        vecs++; if (imem_en !== 1'b0) begin errs++; $display("FAIL stall_imem_en cyc=%0d got %b want 0", k, imem_en); end
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      vecs++;
      if (x !== 1'b1 || p !== ep || w !== rom[ep]) begin
        errs++; $display("FAIL stall_resume got v=%b pc=%h want v=1 pc=%h", x, p, ep);
      end
      ep = ep + 4'h1;
    end
  endtask

  task automatic test_redirect();
    logic [3:0] ep;
    int nx;
    fill_counting_rom();
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 4'h0, x, p, w, e);
    for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 4'h0, x, p, w, e);
    tick(1'b0, 1'b1, 4'hC, x, p, w, e);
    tick(1'b1, 1'b0, 4'h0, x, p, w, e);
    vecs++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL redir_flush got v=%b pc=%h want v=0", dec_valid, p); end
    ep = 4'hC; nx = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      if (x) begin
        vecs++; if (p !== ep || w !== rom[ep]) begin errs++; $display("FAIL redir_seq got pc=%h w=%h want pc=%h", p, w, ep); end
        ep = ep + 4'h1; nx++;
      end
    end
    vecs++; if (nx < 4) begin errs++; $display("FAIL redir_timeout got %0d transfers want >=4", nx); end
  endtask

  task automatic test_halt();
    logic [3:0] ep;
    int nx;
    fill_counting_rom();
    rom[3] = 16'hFC00;
    do_reset();
    ep = 4'h0; nx = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      if (x) begin
        vecs++; if (p !== ep || w !== rom[ep]) begin errs++; $display("FAIL halt_seq got pc=%h w=%h want pc=%h w=%h", p, w, ep, rom[ep]); end
        if (ep == 4'h3) begin
          vecs++; if ({halted, imem_en} !== 2'b10) begin errs++; $display("FAIL halt_flag got halted,en=%b want 10", {halted, imem_en}); end
        end
        ep = ep + 4'h1; nx++;
      end
    end
    vecs++; if (nx !== 4) begin errs++; $display("FAIL halt_count got %0d transfers want 4", nx); end
    vecs++; if ({halted, imem_en, dec_valid} !== 3'b100) begin errs++; $display("FAIL halt_hold got %b want 100", {halted, imem_en, dec_valid}); end
    tick(1'b1, 1'b1, 4'h0, x, p, w, e);
    tick(1'b1, 1'b0, 4'h0, x, p, w, e);
    vecs++; if ({halted, imem_en} !== 2'b01) begin errs++; $display("FAIL halt_resume got halted,en=%b want 01", {halted, imem_en}); end
    ep = 4'h0; nx = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      if (x) begin
        vecs++; if (p !== ep) begin errs++; $display("FAIL halt_refetch got pc=%h want %h", p, ep); end
        ep = ep + 4'h1; nx++;
      end
    end
    vecs++; if (nx < 2) begin errs++; $display("FAIL halt_refetch_timeout got %0d transfers want >=2", nx); end
  endtask

  task automatic test_reset_mid_stall();
    fill_counting_rom();
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 4'h0, x, p, w, e);
    for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 4'h0, x, p, w, e);
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({imem_en, imem_addr, dec_valid, halted, dec_pc, dec_en, dec_opcode} !== 23'h0) begin
      errs++; $display("FAIL async_reset got en=%b addr=%h v=%b h=%b pc=%h den=%h want all 0",
                       imem_en, imem_addr, dec_valid, halted, dec_pc, dec_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 1'b0, 4'h0, x, p, w, e);
      if (k >= 2) begin
        vecs++;
        if (x !== 1'b1 || p !== 4'(k - 2)) begin errs++; $display("FAIL restart got v=%b pc=%h want v=1 pc=%h", x, p, 4'(k - 2)); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_decode_random();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
